// File: rtl/l2c_pkg.sv
// Shared definitions for the L2C tag-array arbiter: FSM state encoding,
// requester index constants and common widths.
package l2c_pkg;

  // One-hot state encoding so each state is a single flop bit.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_LOOKUP = 4'b0010,
    ST_WAIT   = 4'b0100,
    ST_HOLD   = 4'b1000
  } l2c_state_e;

  // Requester slots on the arbiter ports.
  localparam int L2C_REQ_L1  = 0;
  localparam int L2C_REQ_NET = 1;
  localparam int L2C_REQ_MNT = 2;

  localparam int L2C_ADR_W = 32;
  localparam int L2C_WAY_W = 3;

endpackage

// File: rtl/l2c_tag_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping NREQ-1 -> 0.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            any
);

  int            cand;
  logic [IW-1:0] cand_idx;

  // Scan NREQ slots starting at ptr; the first requesting slot wins.
  always_comb begin
    onehot   = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any              = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2c_tag_arb.sv
// L2C tag-array arbiter. Grants one requester at a time, issues a single tag
// lookup, returns the result to that requester and then holds the line lock
// until the requester releases it (or the watchdog forces it free).
//
// Handshake: i_req is a level held by a requester until its grant has been
// released. o_gnt (one-hot, registered) marks ownership; o_tag_valid strobes
// for exactly one cycle in the grant cycle. The first cycle in Wait with any
// of i_tag_hit/miss/retry set is the result; o_resp_valid pulses one cycle
// later to the owner. The owner ends Hold by pulsing i_rel or dropping i_req.
module l2c_tag_arb
  import l2c_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int HOLD_MAX = 255,
  parameter int CNT_W    = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   i_ctl_en,
  input  logic [NREQ-1:0]        i_req,
  input  logic [NREQ*32-1:0]     i_adr,
  input  logic [NREQ-1:0]        i_wen,
  input  logic [NREQ-1:0]        i_rel,
  output logic [NREQ-1:0]        o_gnt,
  output logic                   o_tag_valid,
  output logic [L2C_ADR_W-1:0]   o_tag_adr,
  output logic                   o_tag_wen,
  input  logic                   i_tag_hit,
  input  logic                   i_tag_miss,
  input  logic                   i_tag_retry,
  input  logic [L2C_WAY_W-1:0]   i_tag_way,
  output logic [NREQ-1:0]        o_resp_valid,
  output logic                   o_resp_hit,
  output logic                   o_resp_miss,
  output logic                   o_resp_retry,
  output logic [L2C_WAY_W-1:0]   o_resp_way,
  output logic                   o_busy,
  output logic                   o_fault,
  output logic [3:0]             o_dbg_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  l2c_state_e     state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  gnt_idx;
  logic [IW-1:0]  rr_next;
  logic [CNT_W-1:0] wdog;
  logic [CNT_W-1:0] wdog_next;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  logic [L2C_ADR_W-1:0] adr_arr [NREQ];
  logic                 tag_any;
  logic                 owner_req;
  logic                 owner_rel;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (i_req),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Unpack the flat address bus into one word per requester.
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      adr_arr[k] = i_adr[32*k +: 32];
    end
  end

  assign rr_next     = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
  assign wdog_next   = wdog + 1'b1;
  assign tag_any     = i_tag_hit | i_tag_miss | i_tag_retry;
  assign owner_req   = i_req[gnt_idx];
  assign owner_rel   = i_rel[gnt_idx];
  assign o_busy      = (state != ST_IDLE);
  assign o_dbg_state = state;

  // Arbiter FSM with registered grant, tag request, result and watchdog.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      wdog         <= '0;
      o_gnt        <= '0;
      o_tag_valid  <= 1'b0;
      o_tag_adr    <= '0;
      o_tag_wen    <= 1'b0;
      o_resp_valid <= '0;
      o_resp_hit   <= 1'b0;
      o_resp_miss  <= 1'b0;
      o_resp_retry <= 1'b0;
      o_resp_way   <= '0;
      o_fault      <= 1'b0;
    end else begin
      // Result strobe and its qualifiers are single-cycle.
      o_resp_valid <= '0;
      o_resp_hit   <= 1'b0;
      o_resp_miss  <= 1'b0;
      o_resp_retry <= 1'b0;
      o_resp_way   <= '0;

      case (state)
        ST_IDLE: begin
          if (i_ctl_en && pick_any) begin
            state       <= ST_LOOKUP;
            gnt_idx     <= pick_idx;
            o_gnt       <= pick_onehot;
            o_tag_valid <= 1'b1;
            o_tag_adr   <= adr_arr[pick_idx];
            o_tag_wen   <= i_wen[pick_idx];
          end
        end

        ST_LOOKUP: begin
          o_tag_valid <= 1'b0;
          state       <= ST_WAIT;
        end

        ST_WAIT: begin
          if (tag_any) begin
            // retry outranks miss, miss outranks hit.
            o_resp_valid <= o_gnt;
            o_resp_retry <= i_tag_retry;
            o_resp_miss  <= ~i_tag_retry & i_tag_miss;
            o_resp_hit   <= ~i_tag_retry & ~i_tag_miss & i_tag_hit;
            o_resp_way   <= i_tag_way;
            if (i_tag_retry || !owner_req) begin
              // Retried or withdrawn: give the lock back without Hold.
              state  <= ST_IDLE;
              o_gnt  <= '0;
              rr_ptr <= rr_next;
            end else begin
              state <= ST_HOLD;
              wdog  <= '0;
            end
          end
        end

        ST_HOLD: begin
          if (owner_rel || !owner_req) begin
            state  <= ST_IDLE;
            o_gnt  <= '0;
            rr_ptr <= rr_next;
          end else if (wdog_next == CNT_W'(HOLD_MAX)) begin
            // Owner never released: free the line and flag it permanently.
            o_fault <= 1'b1;
            state   <= ST_IDLE;
            o_gnt   <= '0;
            rr_ptr  <= rr_next;
            wdog    <= wdog_next;
          end else begin
            wdog <= wdog_next;
          end
        end

        default: begin
          state <= ST_IDLE;
          o_gnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2c_tag_arb.sv
// Directed bench for l2c_tag_arb (NREQ=3, HOLD_MAX=4).
module tb_l2c_tag_arb;
  import l2c_pkg::*;

  localparam int NREQ     = 3;
  localparam int HOLD_MAX = 4;
  localparam int CNT_W    = 8;

  // Result kinds for run_op.
  localparam int K_HIT   = 0;
  localparam int K_MISS  = 1;
  localparam int K_RETRY = 2;

  logic              Clk;
  logic              Reset;
  logic              i_ctl_en;
  logic [NREQ-1:0]   i_req;
  logic [NREQ*32-1:0] i_adr;
  logic [NREQ-1:0]   i_wen;
  logic [NREQ-1:0]   i_rel;
  logic [NREQ-1:0]   o_gnt;
  logic              o_tag_valid;
  logic [31:0]       o_tag_adr;
  logic              o_tag_wen;
  logic              i_tag_hit;
  logic              i_tag_miss;
  logic              i_tag_retry;
  logic [2:0]        i_tag_way;
  logic [NREQ-1:0]   o_resp_valid;
  logic              o_resp_hit;
  logic              o_resp_miss;
  logic              o_resp_retry;
  logic [2:0]        o_resp_way;
  logic              o_busy;
  logic              o_fault;
  logic [3:0]        o_dbg_state;

  int checks;
  int errors;

  l2c_tag_arb #(
    .NREQ     (NREQ),
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (CNT_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_ctl_en     (i_ctl_en),
    .i_req        (i_req),
    .i_adr        (i_adr),
    .i_wen        (i_wen),
    .i_rel        (i_rel),
    .o_gnt        (o_gnt),
    .o_tag_valid  (o_tag_valid),
    .o_tag_adr    (o_tag_adr),
    .o_tag_wen    (o_tag_wen),
    .i_tag_hit    (i_tag_hit),
    .i_tag_miss   (i_tag_miss),
    .i_tag_retry  (i_tag_retry),
    .i_tag_way    (i_tag_way),
    .o_resp_valid (o_resp_valid),
    .o_resp_hit   (o_resp_hit),
    .o_resp_miss  (o_resp_miss),
    .o_resp_retry (o_resp_retry),
    .o_resp_way   (o_resp_way),
    .o_busy       (o_busy),
    .o_fault      (o_fault),
    .o_dbg_state  (o_dbg_state)
  );

  // Clock and reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_tag(input logic hit, input logic miss, input logic retry, input logic [2:0] way);
    i_tag_hit   = hit;
    i_tag_miss  = miss;
    i_tag_retry = retry;
    i_tag_way   = way;
  endtask

  // One full grant: grant cycle, Lookup, result in the first Wait cycle,
  // then (hit/miss with do_rel) a release pulse from the owner.
  task automatic run_op(input string name, input logic [2:0] exp_gnt, input logic [31:0] exp_adr,
                        input logic exp_wen, input int kind, input logic [2:0] way, input bit do_rel);
    tick();
    check({name, "_gnt"}, 32'(o_gnt), 32'(exp_gnt));
    check({name, "_tag_valid"}, 32'(o_tag_valid), 32'd1);
    check({name, "_tag_adr"}, o_tag_adr, exp_adr);
    check({name, "_tag_wen"}, 32'(o_tag_wen), 32'(exp_wen));
    tick();
    check({name, "_tag_valid_drop"}, 32'(o_tag_valid), 32'd0);
    check({name, "_state_wait"}, 32'(o_dbg_state), 32'(ST_WAIT));
    set_tag(kind == K_HIT, kind == K_MISS, kind == K_RETRY, way);
    tick();
    set_tag(1'b0, 1'b0, 1'b0, 3'd0);
    check({name, "_resp_valid"}, 32'(o_resp_valid), 32'(exp_gnt));
    check({name, "_resp_hit"}, 32'(o_resp_hit), 32'(kind == K_HIT));
    check({name, "_resp_miss"}, 32'(o_resp_miss), 32'(kind == K_MISS));
    check({name, "_resp_retry"}, 32'(o_resp_retry), 32'(kind == K_RETRY));
    check({name, "_resp_way"}, 32'(o_resp_way), 32'(way));
    if (kind == K_RETRY) begin
      check({name, "_retry_gnt_clr"}, 32'(o_gnt), 32'd0);
      check({name, "_retry_idle"}, 32'(o_dbg_state), 32'(ST_IDLE));
    end else begin
      check({name, "_hold"}, 32'(o_dbg_state), 32'(ST_HOLD));
      if (do_rel) begin
        i_rel = exp_gnt;
        tick();
        i_rel = '0;
        check({name, "_rel_gnt_clr"}, 32'(o_gnt), 32'd0);
        check({name, "_rel_busy"}, 32'(o_busy), 32'd0);
      end
    end
  endtask

  // Directed sequence
  initial begin
    checks      = 0;
    errors      = 0;
    Reset       = 1'b1;
    i_ctl_en    = 1'b0;
    i_req       = '0;
    i_adr       = {32'h0000_30C0, 32'h0000_2080, 32'h0000_1040};
    i_wen       = 3'b110;
    i_rel       = '0;
    set_tag(1'b0, 1'b0, 1'b0, 3'd0);

    // Reset values
    tick();
    tick();
    check("rst_gnt", 32'(o_gnt), 32'd0);
    check("rst_tag_valid", 32'(o_tag_valid), 32'd0);
    check("rst_tag_adr", o_tag_adr, 32'd0);
    check("rst_resp_valid", 32'(o_resp_valid), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    check("rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    Reset = 1'b0;
    tick();

    // Disabled: no grant; a tag result in Idle is ignored
    i_req = 3'b001;
    set_tag(1'b1, 1'b0, 1'b0, 3'd7);
    tick();
    set_tag(1'b0, 1'b0, 1'b0, 3'd0);
    check("dis_gnt", 32'(o_gnt), 32'd0);
    check("dis_busy", 32'(o_busy), 32'd0);
    tick();
    check("idle_tag_ignored", 32'(o_resp_valid), 32'd0);

    // Test 1: single hit, result in 2nd Wait cycle
    i_ctl_en = 1'b1;
    tick();
    check("t1_gnt", 32'(o_gnt), 32'h1);
    check("t1_tag_valid", 32'(o_tag_valid), 32'd1);
    check("t1_tag_adr", o_tag_adr, 32'h0000_1040);
    check("t1_tag_wen", 32'(o_tag_wen), 32'd0);
    i_ctl_en = 1'b0;
    i_rel    = 3'b001;
    tick();
    i_rel = '0;
    check("t1_wait", 32'(o_dbg_state), 32'(ST_WAIT));
    check("t1_tag_valid_drop", 32'(o_tag_valid), 32'd0);
    check("t1_adr_stable", o_tag_adr, 32'h0000_1040);
    tick();
    check("t1_wait2", 32'(o_dbg_state), 32'(ST_WAIT));
    check("t1_gnt_kept", 32'(o_gnt), 32'h1);
    set_tag(1'b1, 1'b0, 1'b0, 3'd5);
    tick();
    set_tag(1'b0, 1'b0, 1'b0, 3'd0);
    check("t1_resp_valid", 32'(o_resp_valid), 32'h1);
    check("t1_resp_hit", 32'(o_resp_hit), 32'd1);
    check("t1_resp_way", 32'(o_resp_way), 32'd5);
    check("t1_hold", 32'(o_dbg_state), 32'(ST_HOLD));
    i_ctl_en = 1'b1;
    tick();
    check("t1_resp_pulse", 32'(o_resp_valid), 32'd0);
    i_rel = 3'b010;
    tick();
    check("t1_foreign_rel", 32'(o_dbg_state), 32'(ST_HOLD));
    check("t1_gnt_hold", 32'(o_gnt), 32'h1);
    i_rel = 3'b001;
    tick();
    i_rel = '0;
    check("t1_rel_gnt", 32'(o_gnt), 32'd0);
    check("t1_rel_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    // rr_ptr is now 1: with 0 and 1 requesting, 1 wins
    i_req = 3'b011;
    run_op("t1_ptr", 3'b010, 32'h0000_2080, 1'b1, K_HIT, 3'd3, 1'b1);

    // Test 2: fairness from rr_ptr=0
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    i_req = 3'b111;
    run_op("t2_a", 3'b001, 32'h0000_1040, 1'b0, K_HIT, 3'd0, 1'b1);
    run_op("t2_b", 3'b010, 32'h0000_2080, 1'b1, K_HIT, 3'd1, 1'b1);
    run_op("t2_c", 3'b100, 32'h0000_30C0, 1'b1, K_HIT, 3'd2, 1'b1);
    run_op("t2_d", 3'b001, 32'h0000_1040, 1'b0, K_HIT, 3'd4, 1'b1);

    // Test 3: retry, then requester 2 is next
    i_req = 3'b010;
    run_op("t3_retry", 3'b010, 32'h0000_2080, 1'b1, K_RETRY, 3'd0, 1'b0);
    i_req = 3'b110;
    run_op("t3_next", 3'b100, 32'h0000_30C0, 1'b1, K_HIT, 3'd1, 1'b1);

    // Test 5: withdraw during Wait, miss result
    i_req = 3'b001;
    tick();
    check("t5_gnt", 32'(o_gnt), 32'h1);
    tick();
    i_req = 3'b000;
    tick();
    check("t5_gnt_kept", 32'(o_gnt), 32'h1);
    set_tag(1'b1, 1'b1, 1'b0, 3'd2);
    tick();
    set_tag(1'b0, 1'b0, 1'b0, 3'd0);
    check("t5_resp_valid", 32'(o_resp_valid), 32'h1);
    check("t5_resp_miss", 32'(o_resp_miss), 32'd1);
    check("t5_resp_hit", 32'(o_resp_hit), 32'd0);
    check("t5_gnt_clr", 32'(o_gnt), 32'd0);
    check("t5_idle", 32'(o_dbg_state), 32'(ST_IDLE));

    // Test 4: watchdog, rr_ptr=1 so requester 1 wins
    i_req = 3'b010;
    run_op("t4", 3'b010, 32'h0000_2080, 1'b1, K_MISS, 3'd6, 1'b0);
    repeat (HOLD_MAX - 1) tick();
    check("t4_still_hold", 32'(o_dbg_state), 32'(ST_HOLD));
    check("t4_no_fault_yet", 32'(o_fault), 32'd0);
    tick();
    check("t4_forced_idle", 32'(o_dbg_state), 32'(ST_IDLE));
    check("t4_forced_gnt", 32'(o_gnt), 32'd0);
    check("t4_fault", 32'(o_fault), 32'd1);
    i_req = 3'b000;
    repeat (3) tick();
    check("t4_fault_sticky", 32'(o_fault), 32'd1);

    // Test 6: async reset mid-Wait (rr_ptr=2)
    i_req = 3'b110;
    tick();
    check("t6_gnt", 32'(o_gnt), 32'h4);
    tick();
    check("t6_wait", 32'(o_dbg_state), 32'(ST_WAIT));
    #2 Reset = 1'b1;
    #1;
    check("t6_rst_gnt", 32'(o_gnt), 32'd0);
    check("t6_rst_busy", 32'(o_busy), 32'd0);
    check("t6_rst_fault", 32'(o_fault), 32'd0);
    check("t6_rst_tag_adr", o_tag_adr, 32'd0);
    check("t6_rst_state", 32'(o_dbg_state), 32'(ST_IDLE));
    #2 Reset = 1'b0;
    i_req = 3'b111;
    run_op("t6_after", 3'b001, 32'h0000_1040, 1'b0, K_HIT, 3'd4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
